// File: rtl/multibyte_add_ctrl.sv
// rtl/multibyte_add_ctrl.sv - byte-serial NBYTES-wide add/subtract sequencer
// Drives an external 8-bit full adder one byte per cycle, LSB first, chaining carry through a register.
module multibyte_add_ctrl #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          sub_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last_byte;

  assign accept    = (state == IDLE) && start;
  assign last_byte = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = 8'h00;
    add_b      = 8'h00;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[8*idx +: 8];
        // Subtraction is A + ~B + 1; the +1 comes from carry_reg seeded with sub.
        add_b   = b_reg[8*idx +: 8] ^ {8{sub_reg}};
        add_cin = carry_reg;
        if (last_byte) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= op_b;
      sub_reg   <= sub;
      carry_reg <= sub;
      idx       <= '0;
    end else if (state == RUN) begin
      result[8*idx +: 8] <= add_sum;
      carry_reg          <= add_cout;
      idx                <= idx + 1'b1;
      if (last_byte) begin
        carry_out <= add_cout;
        // Carry into the sign bit XOR carry out of it flags signed overflow.
        overflow  <= (add_a[7] ^ add_b[7] ^ add_sum[7]) ^ add_cout;
      end
    end
  end

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// tb/tb_multibyte_add_ctrl.sv - directed self-checking bench for multibyte_add_ctrl
// Models the downstream 8-bit adder and checks each operation against hand-computed results.
module tb_multibyte_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;

  int compared;
  int mismatched;

  multibyte_add_ctrl #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      compared++;
      assert ((busy & done) === 1'b0) else begin
        mismatched++;
        $error("FAIL busy_and_done observed=%b expected=0", busy & done);
      end
    end
  end

  // Moves to the next cycle (IDLE), pulses start, then waits for done while counting busy cycles.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic glitch,
                        input logic [31:0] exp_res, input logic exp_c, input logic exp_v);
    int cyc;
    int busy_cnt;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (glitch && cyc == 2) begin
        op_a = 32'h12345678; op_b = 32'h0F0F0F0F; sub = ~s; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, cyc, 5);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_cout"}, {31'b0, carry_out}, {31'b0, exp_c});
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_v});
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_result", result, 32'h0);
    check("rst_adder_in", {15'b0, add_cin, add_a, add_b}, 0);
    rst_n = 1'b1;

    run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("t3", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("t4a", 32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("t4b", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("t5_glitch", 32'h00001234, 32'h00000111, 1'b0, 1'b1, 32'h00001345, 1'b0, 1'b0);
    run_op("t5_b2b", 32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);

    @(posedge clk); #1;
    check("idle_result_held", result, 32'h80000000);
    check("idle_adder_in", {15'b0, add_cin, add_a, add_b}, 0);

    op_a = 32'h01010101; op_b = 32'h01010101; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("t6_in_run", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_done", {31'b0, done}, 0);
    check("t6_result", result, 32'h0);
    check("t6_flags", {30'b0, carry_out, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int seen_done;
      seen_done = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done === 1'b1) seen_done++;
      end
      check("t6_no_done", seen_done, 0);
    end

    run_op("t6_after", 32'h89ABCDEF, 32'h76543211, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("t7_sub_eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
